// File: rtl/dmem_ctrl_if.sv
// Requester and memory-side bundle for the data memory controller.
// Two requester ports share one word-wide, single-port memory.
interface dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;

  logic [1:0]                 req_i;
  logic [1:0][ADDR_WIDTH-1:0] addr_i;
  logic [1:0]                 we_i;
  logic [1:0][BW-1:0]         be_i;
  logic [1:0][DATA_WIDTH-1:0] wdata_i;
  logic [1:0]                 gnt_o;
  logic [1:0]                 rvalid_o;
  logic [DATA_WIDTH-1:0]      rdata_o;
  logic                       mem_en_o;
  logic [ADDR_WIDTH-1:0]      mem_addr_o;
  logic                       mem_we_o;
  logic [DATA_WIDTH-1:0]      mem_wdata_o;
  logic [DATA_WIDTH-1:0]      mem_rdata_i;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    input  mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output mem_en_o, mem_addr_o, mem_we_o, mem_wdata_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    output mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  mem_en_o, mem_addr_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Round-robin two-port arbiter with read-modify-write for sub-word stores
// in front of a single-port, full-word-write data memory.
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic       clk_i,
  input logic       rst_ni,
  dmem_ctrl_if.slave bus
);
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, MERGE} state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BW-1:0]         be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  sel;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [BW-1:0]         sbe;
  logic                  swe;
  logic                  is_rd, is_full, is_none, is_part;
  logic [DATA_WIDTH-1:0] merged;

  logic [1:0]            gnt;
  logic                  en, we;
  logic [ADDR_WIDTH-1:0] maddr;
  logic [DATA_WIDTH-1:0] mwdata;

  logic unused_lsb;
  assign unused_lsb = ^{bus.addr_i[0][1:0], bus.addr_i[1][1:0]};

  assign sel   = (&bus.req_i) ? ~last_q : bus.req_i[1];
  assign waddr = {bus.addr_i[sel][ADDR_WIDTH-1:2], 2'b00};
  assign sbe   = bus.be_i[sel];
  assign swe   = bus.we_i[sel];

  assign is_rd   = ~swe;
  assign is_full = swe & (&sbe);
  assign is_none = swe & ~(|sbe);
  assign is_part = swe & ~(&sbe) & (|sbe);

  always_comb begin
    merged = '0;
    for (int k = 0; k < BW; k++) begin
      merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8]
                                 : bus.mem_rdata_i[8*k +: 8];
    end
  end

  always_comb begin
    gnt      = '0;
    en       = 1'b0;
    we       = 1'b0;
    maddr    = '0;
    mwdata   = '0;
    state_d  = state_q;
    last_d   = last_q;
    rvalid_d = '0;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          gnt[sel] = 1'b1;
          last_d   = sel;
          unique case (1'b1)
            is_rd: begin
              en            = 1'b1;
              maddr         = waddr;
              rvalid_d[sel] = 1'b1;
            end
            is_full: begin
              en     = 1'b1;
              we     = 1'b1;
              maddr  = waddr;
              mwdata = bus.wdata_i[sel];
            end
            is_none: ;
            is_part: begin
              en      = 1'b1;
              maddr   = waddr;
              addr_d  = waddr;
              be_d    = sbe;
              wdata_d = bus.wdata_i[sel];
              state_d = MERGE;
            end
            default: ;
          endcase
        end
      end
      MERGE: begin
        en      = 1'b1;
        we      = 1'b1;
        maddr   = addr_q;
        mwdata  = merged;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      rvalid_q <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  // Memory-facing outputs are combinational, so hold them quiet in reset.
  assign bus.gnt_o       = rst_ni ? gnt : 2'b00;
  assign bus.mem_en_o    = rst_ni & en;
  assign bus.mem_we_o    = rst_ni & we;
  assign bus.mem_addr_o  = rst_ni ? maddr : '0;
  assign bus.mem_wdata_o = rst_ni ? mwdata : '0;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.rdata_o     = bus.mem_rdata_i;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table plus multi-cycle sequences.
// A small word memory model with one-cycle registered read sits behind it.
module tb_dmem_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  logic [31:0] mem_rd_q = '0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_a = '0;
  logic [31:0] poke_d = '0;

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_a] <= poke_d;
    else if (bus.mem_en_o && bus.mem_we_o)
      mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
    else if (bus.mem_en_o)
      mem_rd_q <= mem[bus.mem_addr_o[9:2]];
  end
  assign bus.mem_rdata_i = mem_rd_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.req_i   = '0;
    bus.addr_i  = '0;
    bus.we_i    = '0;
    bus.be_i    = '0;
    bus.wdata_i = '0;
  endtask

  task automatic drive(input int p, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_i[p]   = 1'b1;
    bus.we_i[p]    = w;
    bus.be_i[p]    = b;
    bus.addr_i[p]  = a;
    bus.wdata_i[p] = d;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    poke_a  = a[9:2];
    poke_d  = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          p;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic        mwe;
    logic [1:0]  rv;
    logic [31:0] rdata;
    logic        mg;
    logic [31:0] mdata;
  } vec_t;

  vec_t v [9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  eg;
    logic [31:0] pdata;
    int          k;

    v[0] = '{0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 2'b01,
             32'hDEADBEEF, 1'b0, 32'h0};
    v[1] = '{1, 1'b1, 4'b0110, 32'h20, 32'hAABBCCDD, 1'b1, 1'b0, 2'b00,
             32'h0, 1'b1, 32'h11BBCC44};
    v[2] = '{0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 1'b0, 2'b01,
             32'h11BBCC44, 1'b0, 32'h0};
    v[3] = '{1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 1'b1, 1'b1, 2'b00,
             32'h0, 1'b0, 32'h0};
    v[4] = '{1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 1'b0, 2'b10,
             32'hCAFEF00D, 1'b0, 32'h0};
    v[5] = '{0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 1'b0, 1'b0, 2'b00,
             32'h0, 1'b0, 32'h0};
    v[6] = '{0, 1'b0, 4'h0, 32'h43, 32'h0, 1'b1, 1'b0, 2'b01,
             32'hCAFEF00D, 1'b0, 32'h0};
    v[7] = '{1, 1'b1, 4'b1000, 32'h42, 32'h12000000, 1'b1, 1'b0, 2'b00,
             32'h0, 1'b1, 32'h12FEF00D};
    v[8] = '{0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 1'b0, 2'b01,
             32'h12FEF00D, 1'b0, 32'h0};

    // Reset with requests pending: everything must stay quiet.
    clr_in();
    drive(0, 1'b1, 4'hF, 32'h10, 32'h12345678);
    drive(1, 1'b0, 4'h0, 32'h20, 32'h0);
    #2;
    chk("rst_gnt", {30'd0, bus.gnt_o}, 32'h0);
    chk("rst_en_we", {30'd0, bus.mem_en_o, bus.mem_we_o}, 32'h0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_wdata", bus.mem_wdata_o, 32'h0);
    chk("rst_rvalid", {30'd0, bus.rvalid_o}, 32'h0);
    clr_in();
    poke(32'h10, 32'hDEADBEEF);
    poke(32'h20, 32'h11223344);
    poke(32'h30, 32'h0);
    poke(32'h40, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(v[i].p, v[i].we, v[i].be, v[i].addr, v[i].wdata);
      #1;
      k = 0;
      while (bus.gnt_o[v[i].p] !== 1'b1 && k < 4) begin
        @(negedge clk);
        #1;
        k++;
      end
      eg = (v[i].p == 0) ? 2'b01 : 2'b10;
      chk($sformatf("v%0d_gnt", i), {30'd0, bus.gnt_o}, {30'd0, eg});
      chk($sformatf("v%0d_gnt_lat", i), k, 0);
      chk($sformatf("v%0d_en_we", i), {30'd0, bus.mem_en_o, bus.mem_we_o},
          {30'd0, v[i].en, v[i].mwe});
      if (v[i].en)
        chk($sformatf("v%0d_maddr", i), bus.mem_addr_o,
            v[i].addr & 32'hFFFFFFFC);
      if (v[i].mwe)
        chk($sformatf("v%0d_mwdata", i), bus.mem_wdata_o, v[i].wdata);
      @(negedge clk);
      clr_in();
      #1;
      chk($sformatf("v%0d_rvalid", i), {30'd0, bus.rvalid_o}, {30'd0, v[i].rv});
      if (v[i].rv != 2'b00)
        chk($sformatf("v%0d_rdata", i), bus.rdata_o, v[i].rdata);
      chk($sformatf("v%0d_merge_we", i), {31'd0, bus.mem_we_o},
          {31'd0, v[i].mg});
      if (v[i].mg)
        chk($sformatf("v%0d_merge_data", i), bus.mem_wdata_o, v[i].mdata);
    end

    // Contention from reset: alternate 01,10,... with rvalid one cycle later.
    do_reset();
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 32'h10, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h40, 32'h0);
    #1;
    for (int c = 0; c < 6; c++) begin
      eg = (c % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr%0d_gnt", c), {30'd0, bus.gnt_o}, {30'd0, eg});
      if (c > 0) begin
        pdata = (c % 2 == 1) ? 32'hDEADBEEF : 32'h12FEF00D;
        chk($sformatf("rr%0d_rvalid", c), {30'd0, bus.rvalid_o},
            {30'd0, ~eg});
        chk($sformatf("rr%0d_rdata", c), bus.rdata_o, pdata);
      end
      @(negedge clk);
      #1;
    end
    chk("rr6_rvalid", {30'd0, bus.rvalid_o}, 32'h2);
    chk("rr6_rdata", bus.rdata_o, 32'h12FEF00D);
    clr_in();

    // Partial write on port 0 with a held read of the same word on port 1.
    do_reset();
    @(negedge clk);
    drive(0, 1'b1, 4'b0001, 32'h30, 32'h000000FF);
    drive(1, 1'b0, 4'h0, 32'h30, 32'h0);
    #1;
    chk("mix_T_gnt", {30'd0, bus.gnt_o}, 32'h1);
    @(negedge clk);
    bus.req_i[0] = 1'b0;
    #1;
    chk("mix_T1_gnt", {30'd0, bus.gnt_o}, 32'h0);
    chk("mix_T1_we", {31'd0, bus.mem_we_o}, 32'h1);
    chk("mix_T1_wdata", bus.mem_wdata_o, 32'h000000FF);
    @(negedge clk);
    #1;
    chk("mix_T2_gnt", {30'd0, bus.gnt_o}, 32'h2);
    @(negedge clk);
    clr_in();
    #1;
    chk("mix_T3_rvalid", {30'd0, bus.rvalid_o}, 32'h2);
    chk("mix_T3_rdata", bus.rdata_o, 32'h000000FF);

    // A pending rvalid is cancelled by reset.
    @(negedge clk);
    drive(1, 1'b0, 4'h0, 32'h10, 32'h0);
    #1;
    chk("cx_gnt", {30'd0, bus.gnt_o}, 32'h2);
    @(negedge clk);
    clr_in();
    #1;
    chk("cx_rvalid_pre", {30'd0, bus.rvalid_o}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("cx_rvalid_cancel", {30'd0, bus.rvalid_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the MERGE cycle drops the write.
    @(negedge clk);
    drive(1, 1'b1, 4'b0001, 32'h20, 32'h00000055);
    #1;
    chk("rm_gnt", {30'd0, bus.gnt_o}, 32'h2);
    @(negedge clk);
    clr_in();
    #1;
    chk("rm_merge_we", {31'd0, bus.mem_we_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rm_en_we", {30'd0, bus.mem_en_o, bus.mem_we_o}, 32'h0);
    chk("rm_addr", bus.mem_addr_o, 32'h0);
    chk("rm_wdata", bus.mem_wdata_o, 32'h0);
    chk("rm_gnt_rst", {30'd0, bus.gnt_o}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rm_mem_kept", mem[8], 32'h11BBCC44);
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 32'h20, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h10, 32'h0);
    #1;
    chk("rm_first_gnt", {30'd0, bus.gnt_o}, 32'h1);
    @(negedge clk);
    clr_in();
    #1;
    chk("rm_rvalid", {30'd0, bus.rvalid_o}, 32'h1);
    chk("rm_rdata", bus.rdata_o, 32'h11BBCC44);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
